// File: rtl/nms_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nms_pkg
// Brief    : Shared pixel-word layout and window helpers for the NMS window buffer.
// Revision : 1.0
// ============================================================================
package nms_pkg;

    localparam int X_W     = 10;
    localparam int Y_W     = 10;
    localparam int ISC_W   = 1;
    localparam int SCORE_W = 13;
    localparam int PIX_W   = X_W + Y_W + ISC_W + SCORE_W;

    typedef struct packed {
        logic [SCORE_W-1:0] score;
        logic [ISC_W-1:0]   iscorner;
        logic [Y_W-1:0]     y;
        logic [X_W-1:0]     x;
    } nms_pix_t;

    // Flat element index of window cell (r,c); row 0 / column 0 are the oldest.
    function automatic int win_idx(input int r, input int c, input int win);
        return r * win + c;
    endfunction

    function automatic bit win_legal(input int win);
        return (win >= 3) && ((win % 2) == 1);
    endfunction

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nms_line_ram.sv
`default_nettype none
// ============================================================================
// Module   : nms_line_ram
// Brief    : One line of pixel storage; one write port, one read port,
//            a same-address read in the write cycle returns the old word.
// Revision : 1.0
// ============================================================================
module nms_line_ram
    import nms_pkg::*;
#(
    parameter int DEPTH  = 640,
    parameter int DATA_W = PIX_W
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [addr_w(DEPTH)-1:0]   waddr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [addr_w(DEPTH)-1:0]   raddr_i,
    output logic [DATA_W-1:0]          rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read: the word seen during a write cycle is the pre-write value.
    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/nms_window_buf.sv
`default_nettype none
// ============================================================================
// Module   : nms_window_buf
// Brief    : Raster-stream WIN x WIN sliding window built from WIN-1 cascaded
//            line buffers, with centre coordinates and end-of-frame pulse.
// Options  : NMS_SOF_SYNC_EN adds a sof input that restarts framing at (0,0).
// Revision : 1.0
// ============================================================================
module nms_window_buf
    import nms_pkg::*;
#(
    parameter int COL_NUM = 640,
    parameter int ROW_NUM = 480,
    parameter int DATA_W  = 34,
    parameter int WIN     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_vld,
`ifdef NMS_SOF_SYNC_EN
    input  logic                      sof,
`endif
    input  logic [DATA_W-1:0]         data_in,
    output logic [WIN*WIN*DATA_W-1:0] win_o,
    output logic                      win_vld,
    output logic [15:0]               ctr_x,
    output logic [15:0]               ctr_y,
    output logic                      frame_done
);

    localparam int CW   = addr_w(COL_NUM);
    localparam int RW   = addr_w(ROW_NUM);
    localparam int NLB  = WIN - 1;
    localparam int HALF = (WIN - 1) / 2;

    localparam logic [CW-1:0] C_COL_LAST  = CW'(COL_NUM - 1);
    localparam logic [RW-1:0] C_ROW_LAST  = RW'(ROW_NUM - 1);
    localparam logic [CW-1:0] C_COL_FIRST = CW'(WIN - 1);
    localparam logic [RW-1:0] C_ROW_FIRST = RW'(WIN - 1);

    generate
        if (!win_legal(WIN)) begin : g_bad_win
            $error("nms_window_buf: WIN must be odd and >= 3");
        end
    endgenerate

    logic              w_sof;
`ifdef NMS_SOF_SYNC_EN
    assign w_sof = sof;
`else
    assign w_sof = 1'b0;
`endif

    logic [CW-1:0] col_q, col_d, w_col_pix;
    logic [RW-1:0] row_q, row_d, w_row_pix;
    logic          w_last_col, w_last_row, w_we;

    // Position of the pixel on data_in; sof makes it the first pixel of a frame.
    assign w_col_pix  = w_sof ? '0 : col_q;
    assign w_row_pix  = w_sof ? '0 : row_q;
    assign w_last_col = (w_col_pix == C_COL_LAST);
    assign w_last_row = (w_row_pix == C_ROW_LAST);
    assign w_we       = in_vld & ~rst;

    always_comb begin
        col_d = w_col_pix + CW'(1);
        row_d = w_row_pix;
        if (w_last_col) begin
            col_d = '0;
            row_d = w_last_row ? '0 : w_row_pix + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (in_vld) begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    logic [DATA_W-1:0] w_lb_in  [NLB];
    logic [DATA_W-1:0] w_lb_rd  [NLB];
    logic [DATA_W-1:0] w_col_in [WIN];

    generate
        for (genvar k = 0; k < NLB; k++) begin : g_lb
            if (k == 0) begin : g_head
                assign w_lb_in[k] = data_in;
            end else begin : g_tail
                assign w_lb_in[k] = w_lb_rd[k-1];
            end

            nms_line_ram #(
                .DEPTH  (COL_NUM),
                .DATA_W (DATA_W)
            ) u_ram (
                .clk     (clk),
                .we_i    (w_we),
                .waddr_i (w_col_pix),
                .wdata_i (w_lb_in[k]),
                .raddr_i (w_col_pix),
                .rdata_o (w_lb_rd[k])
            );
        end

        // Newest line enters at the bottom row; the deepest buffer feeds row 0.
        for (genvar r = 0; r < WIN - 1; r++) begin : g_col_in
            assign w_col_in[r] = w_lb_rd[WIN-2-r];
        end
    endgenerate

    assign w_col_in[WIN-1] = data_in;

    logic [DATA_W-1:0] win_q [WIN][WIN];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (in_vld) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][WIN-1] <= w_col_in[r];
            end
        end
    end

    generate
        for (genvar r = 0; r < WIN; r++) begin : g_pack_r
            for (genvar c = 0; c < WIN; c++) begin : g_pack_c
                assign win_o[win_idx(r, c, WIN)*DATA_W +: DATA_W] = win_q[r][c];
            end
        end
    endgenerate

    logic        vld_q, fd_q;
    logic [15:0] ctr_x_q, ctr_y_q;

    // Window validity is purely positional, so wrapped or stale columns never qualify.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            fd_q    <= 1'b0;
            ctr_x_q <= '0;
            ctr_y_q <= '0;
        end else if (in_vld) begin
            vld_q   <= (w_col_pix >= C_COL_FIRST) && (w_row_pix >= C_ROW_FIRST);
            fd_q    <= w_last_col && w_last_row;
            ctr_x_q <= 16'(w_col_pix) - 16'(HALF);
            ctr_y_q <= 16'(w_row_pix) - 16'(HALF);
        end else begin
            vld_q   <= 1'b0;
            fd_q    <= 1'b0;
        end
    end

    assign win_vld    = vld_q;
    assign frame_done = fd_q;
    assign ctr_x      = ctr_x_q;
    assign ctr_y      = ctr_y_q;

endmodule
`default_nettype wire

// File: tb/tb_nms_window_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_nms_window_buf
// Brief    : Self-checking bench driving a WIN=3 and a WIN=5 instance (8x6 frame)
//            from one stream and comparing both against a frame-array model.
// Revision : 1.0
// ============================================================================
module tb_nms_window_buf;

    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int DW   = 34;
    localparam int MAXW = 25 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_vld = 1'b0;
    logic          sof_s = 1'b0;
    logic [DW-1:0] data_in = '0;

    always #5 clk = ~clk;

    logic [9*DW-1:0]  win3;
    logic [25*DW-1:0] win5;
    logic             v3, v5, fd3, fd5;
    logic [15:0]      cx3, cy3, cx5, cy5;

    nms_window_buf #(.COL_NUM(COLS), .ROW_NUM(ROWS), .DATA_W(DW), .WIN(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
`ifdef NMS_SOF_SYNC_EN
        .sof        (sof_s),
`endif
        .data_in    (data_in),
        .win_o      (win3),
        .win_vld    (v3),
        .ctr_x      (cx3),
        .ctr_y      (cy3),
        .frame_done (fd3)
    );

    nms_window_buf #(.COL_NUM(COLS), .ROW_NUM(ROWS), .DATA_W(DW), .WIN(5)) u_dut5 (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
`ifdef NMS_SOF_SYNC_EN
        .sof        (sof_s),
`endif
        .data_in    (data_in),
        .win_o      (win5),
        .win_vld    (v5),
        .ctr_x      (cx5),
        .ctr_y      (cy5),
        .frame_done (fd5)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [MAXW-1:0] act, input logic [MAXW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: the current frame as a 2-D array plus the raster position.
    logic [DW-1:0] pix [ROWS][COLS];
    int mx = 0, my = 0;
    int wc3 = 0, wc5 = 0, fdc3 = 0, fdc5 = 0;
    int acc_cnt = 0;
    bit arm3 = 0, arm5 = 0;

    function automatic logic [MAXW-1:0] exp_win(input int w, input int ax, input int ay);
        logic [MAXW-1:0] v;
        v = '0;
        for (int r = 0; r < w; r++)
            for (int c = 0; c < w; c++)
                v[(r*w+c)*DW +: DW] = pix[ay-(w-1)+r][ax-(w-1)+c];
        return v;
    endfunction

    always @(posedge clk) begin
        bit zchk, acc, e_v3, e_v5, e_fd;
        int ax, ay;
        zchk = 0; acc = 0; ax = 0; ay = 0;
        if (rst) begin
            zchk = 1; mx = 0; my = 0; wc3 = 0; wc5 = 0;
        end else if (in_vld) begin
            acc = 1;
            if (sof_s) begin
                mx = 0; my = 0; wc3 = 0; wc5 = 0;
            end
            ax = mx; ay = my;
            pix[ay][ax] = data_in;
            mx++;
            if (mx == COLS) begin
                mx = 0; my++;
                if (my == ROWS) my = 0;
            end
        end
        #1;
        if (zchk) begin
            chk("rst_vld3", v3, 0);    chk("rst_fd3", fd3, 0);
            chk("rst_ctr3", {cx3, cy3}, 0); chk("rst_win3", win3, 0);
            chk("rst_vld5", v5, 0);    chk("rst_fd5", fd5, 0);
            chk("rst_ctr5", {cx5, cy5}, 0); chk("rst_win5", win5, 0);
        end else begin
            e_v3 = acc && ax >= 2 && ay >= 2;
            e_v5 = acc && ax >= 4 && ay >= 4;
            e_fd = acc && ax == COLS-1 && ay == ROWS-1;
            chk("vld_w3", v3, e_v3);
            chk("vld_w5", v5, e_v5);
            chk("frame_done_w3", fd3, e_fd);
            chk("frame_done_w5", fd5, e_fd);
            if (e_v3) begin
                chk("ctr_x_w3", cx3, ax - 1);
                chk("ctr_y_w3", cy3, ay - 1);
                chk("win_w3", win3, exp_win(3, ax, ay));
            end
            if (e_v5) begin
                chk("ctr_x_w5", cx5, ax - 2);
                chk("ctr_y_w5", cy5, ay - 2);
                chk("win_w5", win5, exp_win(5, ax, ay));
            end
            if (v3) wc3++;
            if (v5) wc5++;
            if (fd3) fdc3++;
            if (fd5) fdc5++;
            if (e_fd) begin
                chk("wins_per_frame_w3", wc3, 24);
                chk("wins_per_frame_w5", wc5, 8);
                wc3 = 0; wc5 = 0;
            end
            if (acc && (arm3 || arm5)) acc_cnt++;
            if (arm3 && v3) begin
                chk("first_win_pixels_w3", acc_cnt, 19);
                chk("first_win_centre_w3", win3[4*DW +: DW], 34'h11);
                chk("first_win_ctr_w3", {cx3, cy3}, {16'd1, 16'd1});
                arm3 = 0;
            end
            if (arm5 && v5) begin
                chk("first_win_pixels_w5", acc_cnt, 37);
                chk("first_win_centre_w5", win5[12*DW +: DW], 34'h22);
                chk("first_win_ctr_w5", {cx5, cy5}, {16'd2, 16'd2});
                arm5 = 0;
            end
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic s, input logic r);
        @(negedge clk);
        in_vld = v; data_in = d; sof_s = s; rst = r;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return DW'({$urandom(), $urandom()});
    endfunction

    // mode 0: row*16+col pattern, 1: random words; gap 0: none, 1: toggle, 2: random
    task automatic frame(input int mode, input int gap);
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                drive(1'b1, (mode == 0) ? DW'(y*16 + x) : rnd_word(), 1'b0, 1'b0);
                if (gap == 1) idle(1);
                else if (gap == 2) idle($urandom_range(0, 2));
            end
        end
    endtask

    task automatic arm();
        arm3 = 1; arm5 = 1; acc_cnt = 0;
    endtask

    task automatic check_armed_seen();
        chk("first_win_seen", {arm3, arm5}, 2'b00);
        arm3 = 0; arm5 = 0;
    endtask

    initial begin
        int f3, f5;
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        idle(1);

        arm(); frame(0, 0); idle(2); check_armed_seen();
        arm(); frame(0, 1); idle(2); check_armed_seen();

        f3 = fdc3; f5 = fdc5;
        frame(1, 0); frame(1, 0); idle(2);
        chk("frame_done_pulses_w3", fdc3 - f3, 2);
        chk("frame_done_pulses_w5", fdc5 - f5, 2);

        for (int i = 0; i < 3*COLS + 4; i++)
            drive(1'b1, DW'((i / COLS)*16 + (i % COLS)), 1'b0, 1'b0);
        drive(1'b1, DW'(3*16 + 4), 1'b0, 1'b1);
        idle(1);
        arm(); frame(0, 0); idle(2); check_armed_seen();

        frame(1, 2); frame(1, 2); idle(2);

`ifdef NMS_SOF_SYNC_EN
        for (int i = 0; i < 2*COLS + 5; i++) drive(1'b1, rnd_word(), 1'b0, 1'b0);
        idle(1);
        f3 = fdc3;
        arm();
        drive(1'b1, DW'(0), 1'b1, 1'b0);
        for (int i = 1; i < COLS*ROWS; i++)
            drive(1'b1, DW'((i / COLS)*16 + (i % COLS)), 1'b0, 1'b0);
        idle(2);
        check_armed_seen();
        chk("sof_frame_done_pulses", fdc3 - f3, 1);
`endif

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/nms_window_buf.md
NMS_WINDOW_BUF -- requirements
Module: nms_window_buf

Interface
REQ-001 SHALL have parameter COL_NUM, default 640, pixels per line.
REQ-002 SHALL have parameter ROW_NUM, default 480, lines per frame.
REQ-003 SHALL have parameter DATA_W, default 34, bits per pixel word.
REQ-004 SHALL have parameter WIN, default 3, window edge (legal: 3, 5, 7).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_vld  input  1  data_in accepted this cycle.
REQ-008 SHALL have port data_in  input  DATA_W  raster-order pixel word.
REQ-009 SHALL have port win_o  output  WIN*WIN*DATA_W  window; element (r,c) at bits [(r*WIN+c)*DATA_W +: DATA_W]; r=0 oldest line, c=0 oldest column.
REQ-010 SHALL have port win_vld  output  1  win_o fully inside the current frame.
REQ-011 SHALL have port ctr_x  output  16  column of window centre.
REQ-012 SHALL have port ctr_y  output  16  row of window centre.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-014 SHALL hold WIN-1 line buffers of COL_NUM x DATA_W each; line k feeds line k+1 (cascade).
REQ-015 SHALL advance line buffers, window shift registers and counters only on cycles with in_vld=1; all state holds otherwise.
REQ-016 SHALL maintain col_cnt (0..COL_NUM-1) and row_cnt (0..ROW_NUM-1); col_cnt wraps to 0 at COL_NUM-1 and increments row_cnt.
REQ-017 SHALL wrap row_cnt to 0 after pixel (COL_NUM-1, ROW_NUM-1) so the next frame restarts cleanly, with no stale row priming.
REQ-018 SHALL update win_o, win_vld, ctr_x and ctr_y one cycle after the accepting edge (latency 1); column WIN-1 of row WIN-1 equals the pixel just accepted.
REQ-019 SHALL assert win_vld iff the accepted pixel had col_cnt>=WIN-1 and row_cnt>=WIN-1; win_vld is low on cycles following in_vld=0.
REQ-020 SHALL drive ctr_x=col-(WIN-1)/2 and ctr_y=row-(WIN-1)/2 of the accepted pixel, zero-extended to 16 bits; value is don't-care when win_vld=0.
REQ-021 SHALL never assert win_vld for windows that straddle a line wrap or a frame wrap.
REQ-022 SHALL pulse frame_done for exactly one cycle, aligned with win_vld of the final window.
REQ-023 SHALL perform a read-before-write per line-buffer address when both occur in the same cycle (old data out).

Reset
REQ-024 SHALL on rst clear col_cnt, row_cnt, all window registers, win_o, win_vld, ctr_x, ctr_y, frame_done to 0; line-buffer RAM contents are not cleared.
REQ-025 SHALL take rst with priority over in_vld; reset mid-frame discards the partial frame; the next accepted pixel is treated as (0,0).

Configuration
REQ-026 SHALL, with macro NMS_SOF_SYNC_EN defined, add input sof (1 bit); sof=1 with in_vld=1 forces that pixel to (0,0), deasserts win_vld and suppresses frame_done for the aborted frame.
REQ-027 SHALL, without NMS_SOF_SYNC_EN, have no sof port; framing derives from counters alone.

Structure
REQ-028 SHALL place the pixel-word field widths (x 10, y 10, iscorner 1, score 13), the window-index packing function, and the legal-WIN check in shared package nms_pkg.
REQ-029 SHALL instantiate one sub-module nms_line_ram (single-port-write, single-port-read, COL_NUM x DATA_W) per line buffer.
REQ-030 SHALL reject illegal WIN (even or <3) at elaboration.

Verification
REQ-031 SHALL cover: COL_NUM=8, ROW_NUM=6, WIN=3, data_in=row*16+col, continuous in_vld -> first win_vld after pixel (2,2), win centre 0x11, ctr=(1,1); 24 valid windows per frame.
REQ-032 SHALL cover: same setup, in_vld toggling 1/0 every cycle -> identical window sequence and values, win_vld never on an in_vld=0 follow-up cycle.
REQ-033 SHALL cover: two back-to-back frames -> frame_done pulses twice, second frame's first win_vld again at (2,2); no window mixes frame-1 data.
REQ-034 SHALL cover: rst asserted at pixel (4,3) -> all outputs 0 next cycle; following frame matches the REQ-031 result.
REQ-035 SHALL cover: WIN=5, COL_NUM=8, ROW_NUM=6 -> first win_vld after pixel (4,4), ctr=(2,2), 8 windows per frame.
REQ-036 SHALL cover, with NMS_SOF_SYNC_EN: sof at pixel (5,2) -> no frame_done for that frame; following frame's first window ctr=(1,1).
